// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA system-RAM arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB      = 1'b0;
    localparam arb_state_t LOCKED_B = 1'b1;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating event counter with synchronous clear; flags when it sits at LIMIT
// (or at LIMIT-1 when EARLY is set, so the caller can act on the final increment).
module mem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4,
    parameter bit          EARLY = 1'b0
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic clr,
    input  logic inc,
    output logic hit_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam int unsigned CMP   = EARLY ? LIMIT - 1 : LIMIT;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_c = (cnt_q == CNT_W'(CMP));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port 64K x 8 RAM between the CPU (port A) and DMA (port B):
// fixed CPU priority, DMA starvation guard, bounded DMA lock bursts, read-data return tag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        AReq,
    input  logic        AWE,
    input  logic [15:0] AAddr,
    input  logic [7:0]  ADataIn,
    output logic        AGnt,
    output logic [7:0]  AData,
    output logic        AValid,
    input  logic        BReq,
    input  logic        BWE,
    input  logic [15:0] BAddr,
    input  logic [7:0]  BDataIn,
    input  logic        BLock,
    output logic        BGnt,
    output logic [7:0]  BData,
    output logic        BValid,
    output logic        MemWE,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemDataIn,
    input  logic [7:0]  MemDataOut
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    rd_tag_t           tag_q;
    rd_tag_t           tag_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              starve_hit;
    logic              burst_pre_hit;
    logic              burst_full;

    // Grant, next state, RAM mux and read tag; grants are held off during reset.
    always_comb begin
        AGnt       = 1'b0;
        BGnt       = 1'b0;
        burst_full = 1'b0;
        state_d    = state_q;
        MemWE      = 1'b0;
        MemAddr    = addr_q;
        MemDataIn  = din_q;
        tag_d      = '0;

        if (RESET_N) begin
            if (state_q == LOCKED_B) begin
                BGnt = BReq;
            end else begin
                BGnt = BReq & (starve_hit | ~AReq);
                AGnt = AReq & ~BGnt;
            end
        end

        // This grant is the last one the lock may take while the CPU waits.
        burst_full = BGnt & AReq & burst_pre_hit;

        case (state_q)
            ARB: begin
                if (BGnt && BLock && !burst_full) begin
                    state_d = LOCKED_B;
                end
            end
            LOCKED_B: begin
                if (!BReq || (BGnt && (!BLock || burst_full))) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase

        if (AGnt) begin
            MemWE      = AWE;
            MemAddr    = AAddr;
            MemDataIn  = ADataIn;
            tag_d.valid = ~AWE;
            tag_d.port  = PORT_A;
        end else if (BGnt) begin
            MemWE      = BWE;
            MemAddr    = BAddr;
            MemDataIn  = BDataIn;
            tag_d.valid = ~BWE;
            tag_d.port  = PORT_B;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ARB;
            tag_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            addr_q  <= MemAddr;
            din_q   <= MemDataIn;
        end
    end

    mem_arb_starve_ctr #(
        .LIMIT (MAX_WAIT),
        .EARLY (1'b0)
    ) u_starve_ctr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clr     (BGnt | ~BReq),
        .inc     (BReq & ~BGnt),
        .hit_c   (starve_hit)
    );

    mem_arb_starve_ctr #(
        .LIMIT (MAX_BURST),
        .EARLY (1'b1)
    ) u_burst_ctr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clr     (state_d == ARB),
        .inc     (BGnt & AReq),
        .hit_c   (burst_pre_hit)
    );

    // The RAM output register is the read pipeline; the tag only steers Valid.
    assign AData  = MemDataOut;
    assign BData  = MemDataOut;
    assign AValid = tag_q.valid & (tag_q.port == PORT_A);
    assign BValid = tag_q.valid & (tag_q.port == PORT_B);

endmodule
